spi_msg_framer: RTL and testbench



---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_msg_framer.sv | 154 +++++++++++++++
 tb/tb_spi_msg_framer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI message path: default payload depth,
// framer FSM encoding and the command codes decoded by the register block.
package spi_pkg;

    localparam int MAX_BYTES_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [7:0] CMD_RESET           = 8'h01;
    localparam logic [7:0] CMD_FORCE_TURBO     = 8'h02;
    localparam logic [7:0] CMD_SET_KEYB_MATRIX = 8'h10;
    localparam logic [7:0] CMD_SET_HCTRL       = 8'h11;
    localparam logic [7:0] CMD_WRITE_KBBUF     = 8'h12;
    localparam logic [7:0] CMD_SET_VIDMODE     = 8'h40;

endpackage

// File: rtl/spi_msg_framer.sv
// Frames each chip-select window into a command byte plus payload, and
// serves the register block's reply to the PHY one byte per slot.
module spi_msg_framer
    import spi_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEFAULT,
    parameter int DATA_W    = 8 * MAX_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_sel,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [7:0]        spi_cmd,
    output logic [DATA_W-1:0] spi_rxdata,
    output logic              spi_msg_end,
    input  logic [DATA_W-1:0] spi_txdata,
    input  logic              spi_txdata_valid,
    output logic              msg_overflow
);

    // idx reaches MAX_BYTES and the reply slot reaches MAX_BYTES+1
    localparam int IDX_W = $clog2(MAX_BYTES + 2);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_BYTES);

    state_e            state_q, state_d;
    logic              sel_q;
    logic [7:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] rxdata_q, rxdata_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        tx_q, tx_d;
    logic              end_q, end_d;
    logic              tx_load_q, tx_load_d;
    logic [IDX_W-1:0]  tx_k_q, tx_k_d;
    logic [7:0]        tx_slot;
    logic              sel_rise;

    assign sel_rise = !sel_q && spi_sel;

    always_comb begin
        tx_slot = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (spi_txdata_valid && tx_k_q == IDX_W'(i)) begin
                tx_slot = spi_txdata[DATA_W-1-8*i -: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rxdata_d  = rxdata_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        tx_d      = tx_q;
        end_d     = 1'b0;
        tx_load_d = 1'b0;
        tx_k_d    = tx_k_q;

        // reply is loaded one cycle after the byte so spi_cmd can be decoded first
        if (tx_load_q) begin
            tx_d = tx_slot;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_rise) begin
                    state_d  = ST_CMD;
                    rxdata_d = '0;
                    idx_d    = '0;
                    ovf_d    = 1'b0;
                    tx_d     = 8'h00;
                end
            end
            ST_CMD: begin
                if (!spi_sel) begin
                    state_d = ST_DONE;
                end else if (rx_valid) begin
                    state_d   = ST_DATA;
                    cmd_d     = rx_byte;
                    tx_load_d = 1'b1;
                    tx_k_d    = '0;
                end
            end
            ST_DATA: begin
                if (!spi_sel) begin
                    state_d = ST_DONE;
                    end_d   = 1'b1;
                end else if (rx_valid) begin
                    if (idx_q < IDX_MAX) begin
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                rxdata_d[DATA_W-1-8*i -: 8] = rx_byte;
                            end
                        end
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    tx_load_d = 1'b1;
                    tx_k_d    = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                // a window opening during DONE is taken straight into CMD
                if (sel_rise) begin
                    state_d  = ST_CMD;
                    rxdata_d = '0;
                    idx_d    = '0;
                    ovf_d    = 1'b0;
                    tx_d     = 8'h00;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            cmd_q     <= 8'h00;
            rxdata_q  <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            tx_q      <= 8'h00;
            end_q     <= 1'b0;
            tx_load_q <= 1'b0;
            tx_k_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= spi_sel;
            cmd_q     <= cmd_d;
            rxdata_q  <= rxdata_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            tx_q      <= tx_d;
            end_q     <= end_d;
            tx_load_q <= tx_load_d;
            tx_k_q    <= tx_k_d;
        end
    end

    assign tx_byte      = tx_q;
    assign spi_cmd      = cmd_q;
    assign spi_rxdata   = rxdata_q;
    assign spi_msg_end  = end_q;
    assign msg_overflow = ovf_q;

endmodule

// File: tb/tb_spi_msg_framer.sv
// Randomised and directed bench for spi_msg_framer against a message-level
// model: each window is a list of bytes, expectations come from that list.
module tb_spi_msg_framer;

    localparam int MAX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sel = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  tx_byte;
    logic [7:0]  spi_cmd;
    logic [63:0] spi_rxdata;
    logic        spi_msg_end;
    logic [63:0] spi_txdata = 64'd0;
    logic        spi_txdata_valid = 1'b0;
    logic        msg_overflow;

    typedef struct {
        logic [7:0]  cmd;
        logic [63:0] rx;
        logic        ovf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] msg_b [0:15];
    logic [7:0] txlog [0:15];
    logic [7:0] tx_lit [0:8];
    int         n_checks = 0;
    int         n_fail = 0;
    logic       prev_end = 1'b0;

    spi_msg_framer #(.MAX_BYTES(MAX)) dut (
        .clk              (clk),
        .reset            (reset),
        .spi_sel          (spi_sel),
        .rx_valid         (rx_valid),
        .rx_byte          (rx_byte),
        .tx_byte          (tx_byte),
        .spi_cmd          (spi_cmd),
        .spi_rxdata       (spi_rxdata),
        .spi_msg_end      (spi_msg_end),
        .spi_txdata       (spi_txdata),
        .spi_txdata_valid (spi_txdata_valid),
        .msg_overflow     (msg_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // payload as seen after the first nbytes of the window (command included)
    function automatic logic [63:0] model_rx(input int nbytes);
        logic [63:0] r = 64'd0;
        for (int p = 1; p < nbytes && p <= MAX; p++) begin
            r = r | ({56'd0, msg_b[p]} << (8 * (MAX - p)));
        end
        return r;
    endfunction

    function automatic logic [7:0] model_tx(input logic [63:0] txd, input bit v, input int j);
        logic [63:0] s;
        if (!v || j >= MAX) return 8'h00;
        s = txd >> (8 * (MAX - 1 - j));
        return s[7:0];
    endfunction

    // Every pulse must be single-cycle and match the oldest completed window.
    always @(negedge clk) begin
        if (reset) begin
            prev_end = 1'b0;
        end else begin
            if (spi_msg_end) begin
                exp_t e;
                check_output("msg_end_width", {63'd0, prev_end}, 64'd0);
                if (exp_q.size() == 0) begin
                    check_output("msg_end_spurious", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("end_cmd", {56'd0, spi_cmd}, {56'd0, e.cmd});
                    check_output("end_rxdata", spi_rxdata, e.rx);
                    check_output("end_overflow", {63'd0, msg_overflow}, {63'd0, e.ovf});
                end
            end
            prev_end = spi_msg_end;
        end
    end

    task automatic apply_stimulus(input int n, input bit v, input logic [63:0] txd,
                                  input bit coincide, input bit rerise, input bit abort);
        exp_t e;
        @(posedge clk) #1;
        spi_txdata = txd;
        spi_txdata_valid = v;
        spi_sel = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("open_rxdata", spi_rxdata, 64'd0);
        check_output("open_overflow", {63'd0, msg_overflow}, 64'd0);
        check_output("open_tx", {56'd0, tx_byte}, 64'd0);
        for (int j = 0; j < n; j++) begin
            @(posedge clk) #1;
            rx_valid = 1'b1;
            rx_byte = msg_b[j];
            @(posedge clk) #1;
            rx_valid = 1'b0;
            @(negedge clk);
            check_output("byte_cmd", {56'd0, spi_cmd}, {56'd0, msg_b[0]});
            check_output("byte_rxdata", spi_rxdata, model_rx(j + 1));
            @(posedge clk);
            @(negedge clk);
            check_output("byte_tx", {56'd0, tx_byte}, {56'd0, model_tx(txd, v, j)});
            txlog[j] = tx_byte;
            repeat ($urandom_range(0, 1)) @(posedge clk);
        end
        if (abort) begin
            @(posedge clk) #1;
            reset = 1'b1;
            spi_sel = 1'b0;
            #2;
            check_output("abort_cmd", {56'd0, spi_cmd}, 64'd0);
            check_output("abort_rxdata", spi_rxdata, 64'd0);
            check_output("abort_msg_end", {63'd0, spi_msg_end}, 64'd0);
            check_output("abort_overflow", {63'd0, msg_overflow}, 64'd0);
            check_output("abort_tx", {56'd0, tx_byte}, 64'd0);
            @(posedge clk) #1;
            reset = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            check_output("abort_no_end", {63'd0, spi_msg_end}, 64'd0);
            return;
        end
        @(posedge clk) #1;
        spi_sel = 1'b0;
        if (coincide) begin
            rx_valid = 1'b1;
            rx_byte = 8'($urandom);
        end
        if (n > 0) begin
            e.cmd = msg_b[0];
            e.rx  = model_rx(n);
            e.ovf = (n - 1 > MAX);
            exp_q.push_back(e);
        end
        @(posedge clk) #1;
        rx_valid = 1'b0;
        if (rerise) spi_sel = 1'b1;
        @(negedge clk);
        check_output("msg_end_timing", {63'd0, spi_msg_end}, (n > 0) ? 64'd1 : 64'd0);
        if (!rerise) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            if (n > 0) begin
                check_output("hold_cmd", {56'd0, spi_cmd}, {56'd0, msg_b[0]});
                check_output("hold_rxdata", spi_rxdata, model_rx(n));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tx_lit = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_cmd", {56'd0, spi_cmd}, 64'd0);
        check_output("reset_rxdata", spi_rxdata, 64'd0);
        check_output("reset_msg_end", {63'd0, spi_msg_end}, 64'd0);
        check_output("reset_overflow", {63'd0, msg_overflow}, 64'd0);
        check_output("reset_tx", {56'd0, tx_byte}, 64'd0);
        @(posedge clk) #1;
        reset = 1'b0;

        msg_b[0] = 8'h10;
        for (int i = 1; i <= 8; i++) msg_b[i] = 8'(i);
        apply_stimulus(9, 1'b1, 64'hDEADBEEF01234567, 1'b0, 1'b0, 1'b0);
        check_output("lit_cmd_10", {56'd0, spi_cmd}, 64'h10);
        check_output("lit_rx_full", spi_rxdata, 64'h0102030405060708);
        check_output("lit_ovf_0", {63'd0, msg_overflow}, 64'd0);
        for (int i = 0; i < 9; i++) check_output("lit_tx_seq", {56'd0, txlog[i]}, {56'd0, tx_lit[i]});

        msg_b[0] = 8'h11; msg_b[1] = 8'hAA; msg_b[2] = 8'h55;
        apply_stimulus(3, 1'b0, 64'hDEADBEEF01234567, 1'b0, 1'b0, 1'b0);
        check_output("lit_rx_short", spi_rxdata, 64'hAA55000000000000);
        check_output("lit_tx_invalid", {56'd0, txlog[0]}, 64'd0);

        msg_b[0] = 8'h12;
        for (int i = 1; i <= 10; i++) msg_b[i] = 8'hA0 + 8'(i);
        apply_stimulus(11, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
        check_output("lit_rx_ovf", spi_rxdata, 64'hA1A2A3A4A5A6A7A8);
        check_output("lit_ovf_1", {63'd0, msg_overflow}, 64'd1);

        apply_stimulus(0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);

        msg_b[0] = 8'h21; msg_b[1] = 8'h33; msg_b[2] = 8'h44;
        apply_stimulus(3, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1);

        msg_b[0] = 8'h02; msg_b[1] = 8'h9F;
        apply_stimulus(2, 1'b1, 64'h1122334455667788, 1'b0, 1'b0, 1'b0);
        check_output("lit_after_reset", spi_rxdata, 64'h9F00000000000000);
        check_output("lit_tx_after_reset", {56'd0, txlog[1]}, 64'h22);

        msg_b[0] = 8'h12; msg_b[1] = 8'hC3; msg_b[2] = 8'h3C;
        apply_stimulus(3, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
        msg_b[0] = 8'h40; msg_b[1] = 8'h5A;
        apply_stimulus(2, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        check_output("lit_rerise_cmd", {56'd0, spi_cmd}, 64'h40);
        check_output("lit_rerise_rx", spi_rxdata, 64'h5A00000000000000);

        for (int m = 0; m < 30; m++) begin
            int n;
            n = $urandom_range(0, 11);
            for (int i = 0; i < 16; i++) msg_b[i] = 8'($urandom);
            apply_stimulus(n, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                           1'($urandom_range(0, 1)),
                           (m < 29) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
        end

        repeat (4) @(posedge clk);
        check_output("pending_msgs", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
